ula_serial: RTL and testbench

ULA_SERIAL -- requirements
Module: ula_serial

---
 rtl/ula_pkg.sv | 19 +
 rtl/ula_slice.sv | 41 ++++
 rtl/ula_serial.sv | 159 +++++++++++++++
 tb/tb_ula_serial.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared types for the bit-serial ALU: opcode encoding and control FSM states.
package ula_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ula_slice.sv
// Combinational SLICE-bit ALU stage; i_cin/o_cout carry for ADD, borrow for SUB.
module ula_slice
  import ula_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_res,
  output logic             o_cout
);

  logic [SLICE:0] w_sum;

  always_comb begin
    w_sum  = '0;
    o_res  = '0;
    o_cout = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
        o_res  = w_sum[SLICE-1:0];
        o_cout = w_sum[SLICE];
      end
      OP_SUB: begin
        // a - b - bin == a + ~b + ~bin; a missing carry-out means a borrow
        w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{SLICE{1'b0}}, ~i_cin};
        o_res  = w_sum[SLICE-1:0];
        o_cout = ~w_sum[SLICE];
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_NOT:  o_res = ~i_a;
      OP_XOR:  o_res = i_a ^ i_b;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/ula_serial.sv
// Slice-serial ALU, WIDTH/SLICE clocks per operation, LSB slice first.
// Define ULA_SERIAL_FLAGS_EN to build the zero/ovf flag logic (tied to 0 otherwise).
module ula_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output state_e           dbg_state
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("ula_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; in_ready is high only in IDLE and out_valid only in DONE.
  state_e             r_state;
  state_e             w_state_nx;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;

  int                 w_idx;
  logic               w_last;
  logic [SLICE-1:0]   w_res;
  logic               w_cout;
  logic [WIDTH-1:0]   w_final;

  assign w_idx  = int'(r_cnt) * SLICE;
  assign w_last = (r_cnt == CNT_W'(N - 1));

  ula_slice #(.SLICE(SLICE)) u_slice (
    .i_a    (r_a[w_idx +: SLICE]),
    .i_b    (r_b[w_idx +: SLICE]),
    .i_op   (r_op),
    .i_cin  (r_carry),
    .o_res  (w_res),
    .o_cout (w_cout)
  );

  // Accumulated result with the slice being processed this cycle merged in.
  always_comb begin
    w_final = r_acc;
    w_final[w_idx +: SLICE] = w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nx = S_RUN;
      S_RUN:   if (w_last)    w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op    <= op;
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_carry <= w_cout;
          r_acc   <= w_final;
          if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_cout;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ULA_SERIAL_FLAGS_EN
  logic r_zero;
  logic r_ovf;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD:  w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_final[WIDTH-1] != r_a[WIDTH-1]);
      OP_SUB:  w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_final[WIDTH-1] != r_a[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_zero <= (w_final == '0);
      r_ovf  <= w_ovf;
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ula_serial.sv
// Randomized + directed bench for ula_serial: WIDTH=8/SLICE=1 and WIDTH=16/SLICE=4 instances.
module tb_ula_serial;
  import ula_pkg::*;

`ifdef ULA_SERIAL_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // narrow instance (WIDTH=8, SLICE=1)
  logic       iv_n = 0, or_n = 0, ci_n = 0;
  logic [2:0] op_n = '0;
  logic [7:0] a_n = '0, b_n = '0;
  logic       ir_n, ov_n, co_n, z_n, of_n;
  logic [7:0] r_n;
  state_e     st_n;

  // wide instance (WIDTH=16, SLICE=4)
  logic        iv_w = 0, or_w = 0, ci_w = 0;
  logic [2:0]  op_w = '0;
  logic [15:0] a_w = '0, b_w = '0;
  logic        ir_w, ov_w, co_w, z_w, of_w;
  logic [15:0] r_w;
  state_e      st_w;

  ula_serial #(.WIDTH(8), .SLICE(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(ir_n), .op(op_n),
    .a(a_n), .b(b_n), .cin(ci_n), .out_valid(ov_n), .out_ready(or_n),
    .result(r_n), .cout(co_n), .zero(z_n), .ovf(of_n), .dbg_state(st_n)
  );

  ula_serial #(.WIDTH(16), .SLICE(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w), .op(op_w),
    .a(a_w), .b(b_w), .cin(ci_w), .out_valid(ov_w), .out_ready(or_w),
    .result(r_w), .cout(co_w), .zero(z_w), .ovf(of_w), .dbg_state(st_w)
  );

  int errors = 0;
  int checks = 0;
  logic [18:0] exp_q[$];   // {result[15:0], cout, zero, ovf}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the whole operands.
  function automatic logic [18:0] model(input int width, input logic [2:0] op,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    longint unsigned mask = (64'd1 << width) - 1;
    longint unsigned ua = a, ub = b, s = 0;
    logic [15:0] res = '0;
    logic co = 0, z, ov = 0;
    int msb = width - 1;
    case (op)
      3'd0: begin
        s   = ua + ub + cin;
        res = 16'(s & mask);
        co  = ((s >> width) & 1) != 0;
        ov  = (a[msb] == b[msb]) && (res[msb] != a[msb]);
      end
      3'd1: begin
        s   = ua - ub - cin;
        res = 16'(s & mask);
        co  = ua < (ub + cin);
        ov  = (a[msb] != b[msb]) && (res[msb] != a[msb]);
      end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = 16'(~ua & mask);
      3'd5: res = a ^ b;
      default: res = '0;
    endcase
    z = (res == 16'd0);
    if (!FLAGS_ON) begin
      z  = 1'b0;
      ov = 1'b0;
    end
    return {res, co, z, ov};
  endfunction

  function automatic logic [18:0] get_out(input bit wide);
    if (wide) return {r_w, co_w, z_w, of_w};
    return {8'h00, r_n, co_n, z_n, of_n};
  endfunction

  // Drive one request, wait for its result, hold out_ready low 'hold' cycles, then consume.
  task automatic run_op(input bit wide, input logic [2:0] op, input logic [15:0] a_in,
                        input logic [15:0] b_in, input logic cin, input int hold,
                        input string name);
    logic [15:0] a, b;
    logic [18:0] want, got;
    int lat, n;
    bit vld;
    a = wide ? a_in : (a_in & 16'h00FF);
    b = wide ? b_in : (b_in & 16'h00FF);
    n = wide ? 4 : 8;
    exp_q.push_back(model(wide ? 16 : 8, op, a, b, cin));

    @(negedge clk);
    check_eq({name, "_in_ready_idle"}, wide ? ir_w : ir_n, 1);
    if (wide) begin iv_w = 1; op_w = op; a_w = a; b_w = b; ci_w = cin; end
    else      begin iv_n = 1; op_n = op; a_n = a[7:0]; b_n = b[7:0]; ci_n = cin; end

    @(posedge clk); #1;
    // Scramble inputs after acceptance; out_ready toggles are harmless before out_valid.
    if (wide) begin
      iv_w = 1'($urandom_range(0, 1)); op_w = 3'($urandom); a_w = 16'($urandom);
      b_w = 16'($urandom); ci_w = 1'($urandom); or_w = 1'($urandom_range(0, 1));
    end else begin
      iv_n = 1'($urandom_range(0, 1)); op_n = 3'($urandom); a_n = 8'($urandom);
      b_n = 8'($urandom); ci_n = 1'($urandom); or_n = 1'($urandom_range(0, 1));
    end

    lat = 0;
    vld = 0;
    while (!vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      vld = wide ? ov_w : ov_n;
      if (vld) begin
        if (wide) or_w = 0; else or_n = 0;
      end
      check_eq({name, "_in_ready_busy"}, wide ? ir_w : ir_n, 0);
    end
    want = exp_q.pop_front();
    if (!vld) begin
      check_eq({name, "_timeout"}, 0, 1);
      return;
    end
    check_eq({name, "_latency"}, lat, n);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      got = get_out(wide);
      check_eq({name, "_hold_valid"}, wide ? ov_w : ov_n, 1);
      check_eq({name, "_hold_result"}, got[18:3], want[18:3]);
      check_eq({name, "_hold_in_ready"}, wide ? ir_w : ir_n, 0);
    end

    got = get_out(wide);
    check_eq({name, "_result"}, got[18:3], want[18:3]);
    check_eq({name, "_cout"}, got[2], want[2]);
    check_eq({name, "_zero"}, got[1], want[1]);
    check_eq({name, "_ovf"}, got[0], want[0]);

    @(negedge clk);
    if (wide) begin or_w = 1; iv_w = 0; end
    else      begin or_n = 1; iv_n = 0; end
    @(posedge clk); #1;
    check_eq({name, "_valid_drop"}, wide ? ov_w : ov_n, 0);
    check_eq({name, "_state_idle"}, 32'(wide ? st_w : st_n), 32'(S_IDLE));
    got = get_out(wide);
    check_eq({name, "_result_kept"}, got[18:3], want[18:3]);
    @(negedge clk);
    if (wide) or_w = 0; else or_n = 0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", ov_n, 0);
    check_eq("rst_result", r_n, 0);
    check_eq("rst_flags", {co_n, z_n, of_n}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", ir_n, 1);
    check_eq("rst_w_in_ready", ir_w, 1);

    // directed
    run_op(0, OP_ADD, 16'h7F, 16'h01, 0, 0, "add_7f_01");
    run_op(0, OP_ADD, 16'hFF, 16'h01, 0, 1, "add_ff_01");
    run_op(0, OP_SUB, 16'h00, 16'h01, 0, 0, "sub_00_01");
    run_op(0, OP_AND, 16'hF0, 16'h3C, 0, 5, "and_hold");
    run_op(0, 3'b111, 16'h55, 16'hAA, 0, 0, "op_111");
    run_op(1, OP_ADD, 16'h1234, 16'h0FFF, 1, 2, "w_add");
    run_op(1, OP_SUB, 16'h8000, 16'h0001, 0, 0, "w_sub_ovf");

    // reset during the 3rd RUN cycle
    @(negedge clk);
    iv_n = 1; op_n = OP_ADD; a_n = 8'h0F; b_n = 8'h01; ci_n = 0;
    @(posedge clk); #1;
    iv_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("mid_rst_valid", ov_n, 0);
    check_eq("mid_rst_result", r_n, 0);
    check_eq("mid_rst_state", 32'(st_n), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_valid", ov_n, 0);
    end
    check_eq("post_rst_result", r_n, 0);
    check_eq("post_rst_cout", co_n, 0);
    check_eq("post_rst_in_ready", ir_n, 1);

    // randomized
    for (int i = 0; i < 30; i++)
      run_op(0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 255)),
             16'($urandom_range(0, 255)), 1'($urandom), $urandom_range(0, 3), "rnd_n");
    for (int i = 0; i < 15; i++)
      run_op(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
             1'($urandom), $urandom_range(0, 3), "rnd_w");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
